// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: NOP encoding and fetch FSM states.
package instruction_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    // Decode only sees bits [31:2]; the low two bits of a 32-bit opcode are always 2'b11.
    localparam logic [29:0] NOP_WORD  = NOP_INSTR[31:2];

    typedef enum logic [1:0] {
        StFetch  = 2'd0,
        StSquash = 2'd1,
        StHold   = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: hold beats flush, flush loads a NOP and leaves pc_o unchanged.
module if_id_stage_reg
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [29:0] ResetPcWord = 30'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hold_i,
    input  logic        flush_i,
    input  logic [29:0] instr_i,
    input  logic [29:0] pc_i,
    output logic [29:0] instr_o,
    output logic [29:0] pc_o
);

    logic [29:0] instr_q;
    logic [29:0] pc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            instr_q <= NOP_WORD;
            pc_q    <= ResetPcWord;
        end else if (!hold_i) begin
            if (flush_i) begin
                instr_q <= NOP_WORD;
            end else begin
                instr_q <= instr_i;
                pc_q    <= pc_i;
            end
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch: one outstanding imem request, squash of in-flight fetches on redirect,
// and a one-entry skid buffer that parks a returned word while IF/ID is held.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        busywait_i,
    input  logic        flush_i,
    input  logic [29:0] branch_target_i,
    output logic        imem_req_o,
    output logic [29:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [29:0] instr_o,
    output logic [29:0] pc_o
);

    localparam logic [29:0] ResetPcWord = RESET_PC[31:2];

    fetch_state_e state_q, state_d;
    logic [29:0]  pc_q, pc_d;
    logic [29:0]  redirect_q, redirect_d;
    logic [29:0]  skid_instr_q, skid_instr_d;
    logic [29:0]  skid_pc_q, skid_pc_d;

    logic         flush_eff;
    logic         hold;
    logic         word_valid;
    logic [29:0]  word_instr;
    logic [29:0]  word_pc;
    logic         unused_rdata;

    assign unused_rdata = ^imem_rdata_i[1:0];

    // A frozen EX re-presents its flush later, so busywait masks it here.
    assign flush_eff = flush_i & ~busywait_i;
    assign hold      = stall_i | busywait_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redirect_d   = redirect_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        word_valid   = 1'b0;
        word_instr   = imem_rdata_i[31:2];
        word_pc      = pc_q;
        case (state_q)
            StFetch: begin
                if (flush_eff) begin
                    if (imem_ready_i) begin
                        pc_d = branch_target_i;
                    end else begin
                        redirect_d = branch_target_i;
                        state_d    = StSquash;
                    end
                end else if (imem_ready_i) begin
                    if (hold) begin
                        skid_instr_d = imem_rdata_i[31:2];
                        skid_pc_d    = pc_q;
                        state_d      = StHold;
                    end else begin
                        word_valid = 1'b1;
                        pc_d       = pc_q + 30'd1;
                    end
                end
            end
            StSquash: begin
                // Address must not move until the stale request completes.
                if (flush_eff) begin
                    redirect_d = branch_target_i;
                end
                if (imem_ready_i) begin
                    pc_d    = flush_eff ? branch_target_i : redirect_q;
                    state_d = StFetch;
                end
            end
            StHold: begin
                if (flush_eff) begin
                    skid_instr_d = 30'h0;
                    skid_pc_d    = 30'h0;
                    pc_d         = branch_target_i;
                    state_d      = StFetch;
                end else if (!hold) begin
                    word_valid = 1'b1;
                    word_instr = skid_instr_q;
                    word_pc    = skid_pc_q;
                    pc_d       = pc_q + 30'd1;
                    state_d    = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StFetch;
            pc_q         <= ResetPcWord;
            redirect_q   <= 30'h0;
            skid_instr_q <= 30'h0;
            skid_pc_q    <= 30'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redirect_q   <= redirect_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

    assign imem_req_o  = rst_i & (state_q != StHold);
    assign imem_addr_o = pc_q;

    if_id_stage_reg #(
        .ResetPcWord (ResetPcWord)
    ) u_if_id (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .hold_i  (busywait_i | (stall_i & ~flush_i)),
        .flush_i (flush_eff | ~word_valid),
        .instr_i (word_instr),
        .pc_i    (word_pc),
        .instr_o (instr_o),
        .pc_o    (pc_o)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomised bench for instruction_fetch_stage against a transaction-level fetch model.
module tb_instruction_fetch_stage;

    localparam logic [29:0] NopW = 30'h0000_0004;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        busywait_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [29:0] branch_target_i = 30'h0;
    logic        imem_req_o;
    logic [29:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic [31:0] imem_rdata_i = 32'h0;
    logic [29:0] instr_o;
    logic [29:0] pc_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    instruction_fetch_stage dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .busywait_i      (busywait_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ready_i    (imem_ready_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_o         (instr_o),
        .pc_o            (pc_o)
    );

    // Model: next fetch address, whether the in-flight fetch is doomed (and where to go
    // after it), a parked-word queue of depth <= 1, and the decode-visible pair.
    typedef struct packed {
        logic [29:0] instr;
        logic [29:0] pc;
    } fetched_t;

    logic [29:0] m_next_addr;
    logic        m_doomed;
    logic [29:0] m_after_doom;
    fetched_t    m_parked[$];
    fetched_t    m_decode;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return 32'h0050_0093 ^ {a[24:0], 7'b0};
    endfunction

    task automatic check(input string name, input logic [29:0] act, input logic [29:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_next_addr  = 30'h0;
        m_doomed     = 1'b0;
        m_after_doom = 30'h0;
        m_parked.delete();
        m_decode     = '{instr: NopW, pc: 30'h0};
    endtask

    task automatic model_advance(input bit s, input bit b, input bit f, input logic [29:0] t,
                                 input bit r);
        bit       redirect;
        bit       frozen;
        bit       have_word;
        fetched_t word;
        redirect  = f && !b;
        frozen    = s || b;
        have_word = 1'b0;
        word      = '{instr: mem_word(m_next_addr) >> 2, pc: m_next_addr};
        if (m_parked.size() != 0) begin
            if (redirect) begin
                m_parked.delete();
                m_next_addr = t;
            end else if (!frozen) begin
                word      = m_parked.pop_front();
                have_word = 1'b1;
                m_next_addr = m_next_addr + 30'd1;
            end
        end else if (m_doomed) begin
            if (redirect) m_after_doom = t;
            if (r) begin
                m_next_addr = redirect ? t : m_after_doom;
                m_doomed    = 1'b0;
            end
        end else if (redirect) begin
            if (r) m_next_addr = t;
            else begin
                m_doomed     = 1'b1;
                m_after_doom = t;
            end
        end else if (r) begin
            if (frozen) m_parked.push_back(word);
            else begin
                have_word   = 1'b1;
                m_next_addr = m_next_addr + 30'd1;
            end
        end
        if (b) begin
        end else if (f) m_decode.instr = NopW;
        else if (s) begin
        end else if (have_word) m_decode = word;
        else m_decode.instr = NopW;
    endtask

    task automatic compare_all();
        bit exp_req;
        exp_req = (m_parked.size() == 0);
        check("imem_req_o", {29'b0, imem_req_o}, {29'b0, exp_req});
        if (exp_req) check("imem_addr_o", imem_addr_o, m_next_addr);
        check("instr_o", instr_o, m_decode.instr);
        check("pc_o", pc_o, m_decode.pc);
    endtask

    task automatic step(input bit s, input bit b, input bit f, input logic [29:0] t, input bit r);
        stall_i         = s;
        busywait_i      = b;
        flush_i         = f;
        branch_target_i = t;
        imem_ready_i    = r;
        imem_rdata_i    = mem_word(imem_addr_o);
        model_advance(s, b, f, t, r);
        @(posedge clk_i);
        #1;
        compare_all();
    endtask

    initial begin
        logic [29:0] a;
        logic [31:0] w;
        bit          s, b, f, r;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check("rst req", {29'b0, imem_req_o}, 30'h0);
            check("rst instr", instr_o, 30'h4);
            check("rst pc", pc_o, 30'h0);
        end
        rst_i = 1'b1;
        #1;
        compare_all();
        check("first addr", imem_addr_o, 30'h0);

        // Back-to-back fetch with ready every cycle.
        step(0, 0, 0, 0, 1);
        check("seq instr0", instr_o, 30'h0014_0024);
        check("seq pc0", pc_o, 30'h0);
        check("seq addr1", imem_addr_o, 30'h1);
        step(0, 0, 0, 0, 1);
        check("seq instr1", instr_o, 30'h0014_0004);
        check("seq pc1", pc_o, 30'h1);
        step(0, 0, 0, 0, 1);
        check("seq pc2", pc_o, 30'h2);
        check("seq addr3", imem_addr_o, 30'h3);

        // Stall while a word returns: it must park, then drain, then fetch continues.
        a = m_next_addr;
        step(1, 0, 0, 0, 1);
        check("stall req", {29'b0, imem_req_o}, 30'h0);
        check("stall pc held", pc_o, a - 30'd1);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        w = mem_word(a);
        check("skid instr", instr_o, w[31:2]);
        check("skid pc", pc_o, a);
        check("skid next addr", imem_addr_o, a + 30'd1);

        // Flush with memory slow: old address held, returned word discarded.
        a = m_next_addr;
        step(0, 0, 1, 30'h40, 0);
        check("squash nop", instr_o, 30'h4);
        step(0, 0, 0, 0, 0);
        check("squash addr held", imem_addr_o, a);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("squash redirect", imem_addr_o, 30'h40);
        check("squash no word", instr_o, 30'h4);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Flush under busywait is ignored; alone next cycle it takes effect.
        step(0, 1, 1, 30'h123, 0);
        check("bw flush addr", imem_addr_o, 30'h42);
        step(0, 0, 1, 30'h40, 1);
        check("flush addr", imem_addr_o, 30'h40);
        check("flush nop", instr_o, 30'h4);

        // Word-address wrap.
        step(0, 0, 1, 30'h3FFF_FFFF, 1);
        check("wrap top", imem_addr_o, 30'h3FFF_FFFF);
        step(0, 0, 0, 0, 1);
        check("wrap addr", imem_addr_o, 30'h0);
        check("wrap pc", pc_o, 30'h3FFF_FFFF);

        for (int i = 0; i < 2000; i++) begin
            s = ($urandom_range(0, 99) < 20);
            b = ($urandom_range(0, 99) < 10);
            f = ($urandom_range(0, 99) < 10);
            r = (m_parked.size() == 0) && ($urandom_range(0, 99) < 60);
            step(s, b, f, 30'($urandom), r);
        end

        // Reset in the middle of a pending request.
        step(0, 0, 0, 0, 0);
        #2;
        rst_i = 1'b0;
        #1;
        check("midrst req", {29'b0, imem_req_o}, 30'h0);
        check("midrst instr", instr_o, 30'h4);
        check("midrst pc", pc_o, 30'h0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        compare_all();
        check("midrst addr", imem_addr_o, 30'h0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
